pattern_scheduler: RTL and testbench

//   Decides which pattern the pattern selector shows and when it switches.
//   - Advances automatically every FRAMES_PER_PATTERN frames.
//   - Also serves manual next/prev requests.
//   - Switches only on frame boundaries, so there is no tearing.
//   - Drives an optional 3-bit fade level that the top level uses to dim

---
 rtl/pattern_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pattern_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scheduler.sv
// pattern_scheduler: picks the active pattern index and times each switch.
// Patterns advance automatically every FRAMES_PER_PATTERN frames or on manual
// next/prev requests, always on a frame boundary. With PATTERN_SCHED_FADE_EN
// defined, each switch is wrapped in a fade-out / fade-in brightness ramp;
// without it, switches happen directly on the serving frame tick and
// fade_level/busy stay at 0.
module pattern_scheduler #(
    parameter int NUM_PATTERNS       = 4,
    parameter int SEL_W              = 2,
    parameter int FRAMES_PER_PATTERN = 300,
    parameter int CNT_W              = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             paused,
    input  logic             auto_en,
    input  logic             next_req,
    input  logic             prev_req,
    output logic [SEL_W-1:0] pattern_sel,
    output logic [2:0]       fade_level,
    output logic             switch_pulse,
    output logic             busy
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_PATTERN - 1);

    // Request bookkeeping shared by both build variants.
    logic             pending;
    logic             dir_dn;
    logic [CNT_W-1:0] frame_cnt;
    logic [SEL_W-1:0] sel_q;
    logic             pulse_q;

    // A simultaneous next+prev cancels out; a lone request carries its own
    // direction and overrides whatever was pending before (last one wins).
    logic req_valid;
    logic pend_eff;
    logic dir_dn_eff;
    logic cnt_run;
    logic cnt_wrap;

    assign req_valid  = next_req ^ prev_req;
    assign pend_eff   = pending | req_valid;
    assign dir_dn_eff = req_valid ? prev_req : dir_dn;
    assign cnt_run    = auto_en & ~paused & ~pend_eff;
    assign cnt_wrap   = cnt_run && (frame_cnt == CNT_LAST);

    // Step the pattern index by +/-1 with wrap-around inside 0..NUM_PATTERNS-1.
    function automatic logic [SEL_W-1:0] step_sel(input logic [SEL_W-1:0] s,
                                                  input logic             dn);
        logic [SEL_W-1:0] r;
        if (dn) begin
            r = (s == '0) ? SEL_LAST : s - 1'b1;
        end else begin
            r = (s >= SEL_LAST) ? '0 : s + 1'b1;
        end
        return r;
    endfunction

    assign pattern_sel  = sel_q;
    assign switch_pulse = pulse_q;

`ifdef PATTERN_SCHED_FADE_EN

    localparam logic [1:0] S_SHOW     = 2'd0;
    localparam logic [1:0] S_FADE_OUT = 2'd1;
    localparam logic [1:0] S_FADE_IN  = 2'd2;

    logic [1:0] state;
    logic [2:0] fade_q;

    assign fade_level = fade_q;
    assign busy       = (state != S_SHOW);

    // Scheduler FSM: latch requests, run the frame counter in SHOW, and walk
    // the fade ramp one step per frame tick, swapping pattern at full dark.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_SHOW;
            fade_q    <= 3'd0;
            sel_q     <= '0;
            pulse_q   <= 1'b0;
            pending   <= 1'b0;
            dir_dn    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (req_valid) begin
                pending <= 1'b1;
                dir_dn  <= prev_req;
            end
            if (frame_tick) begin
                case (state)
                    S_SHOW: begin
                        if (pend_eff) begin
                            state  <= S_FADE_OUT;
                            fade_q <= 3'd1;
                        end else if (cnt_wrap) begin
                            // Auto advance behaves like a queued +1 request so a
                            // manual request during the fade can still override it.
                            frame_cnt <= '0;
                            pending   <= 1'b1;
                            dir_dn    <= 1'b0;
                            state     <= S_FADE_OUT;
                            fade_q    <= 3'd1;
                        end else if (cnt_run) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                    S_FADE_OUT: begin
                        if (fade_q != 3'd7) begin
                            fade_q <= fade_q + 3'd1;
                        end else begin
                            sel_q     <= step_sel(sel_q, dir_dn_eff);
                            pulse_q   <= 1'b1;
                            pending   <= 1'b0;
                            frame_cnt <= '0;
                            state     <= S_FADE_IN;
                        end
                    end
                    S_FADE_IN: begin
                        fade_q <= fade_q - 3'd1;
                        if (fade_q == 3'd1) begin
                            state <= S_SHOW;
                        end
                    end
                    default: begin
                        state  <= S_SHOW;
                        fade_q <= 3'd0;
                    end
                endcase
            end
        end
    end

`else

    assign fade_level = 3'd0;
    assign busy       = 1'b0;

    // Direct switching: latch requests and serve them (or an auto advance)
    // on the next frame tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            pulse_q   <= 1'b0;
            pending   <= 1'b0;
            dir_dn    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (req_valid) begin
                pending <= 1'b1;
                dir_dn  <= prev_req;
            end
            if (frame_tick) begin
                if (pend_eff) begin
                    sel_q     <= step_sel(sel_q, dir_dn_eff);
                    pulse_q   <= 1'b1;
                    pending   <= 1'b0;
                    frame_cnt <= '0;
                end else if (cnt_wrap) begin
                    sel_q     <= step_sel(sel_q, 1'b0);
                    pulse_q   <= 1'b1;
                    frame_cnt <= '0;
                end else if (cnt_run) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler (NUM_PATTERNS=3, FRAMES_PER_PATTERN=4).
// Handles both builds: fade ramp when PATTERN_SCHED_FADE_EN is defined,
// direct switching otherwise.
module tb_pattern_scheduler;

    localparam int NP = 3;
    localparam int FP = 4;
`ifdef PATTERN_SCHED_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       paused = 1'b0;
    logic       auto_en = 1'b0;
    logic       next_req = 1'b0;
    logic       prev_req = 1'b0;
    logic [1:0] pattern_sel;
    logic [2:0] fade_level;
    logic       switch_pulse;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    pattern_scheduler #(
        .NUM_PATTERNS(NP), .SEL_W(2), .FRAMES_PER_PATTERN(FP), .CNT_W(2)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .paused(paused),
        .auto_en(auto_en), .next_req(next_req), .prev_req(prev_req),
        .pattern_sel(pattern_sel), .fade_level(fade_level),
        .switch_pulse(switch_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a transition is tracked as the number of ticks elapsed
    // since it started (phase 0..13, -1 = showing). Fade level follows the
    // ramp 1..7, 7 (switch), 6..0.
    int m_sel, m_pend, m_dir, m_cnt, m_phase, m_pulse;

    function automatic int m_fade();
        if (!FADE || m_phase < 0) return 0;
        if (m_phase <= 6) return m_phase + 1;
        if (m_phase == 7) return 7;
        return 14 - m_phase;
    endfunction

    task automatic m_switch();
        m_sel   = (m_sel + m_dir + NP) % NP;
        m_pulse = 1;
        m_pend  = 0;
        m_cnt   = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            m_sel = 0; m_pend = 0; m_dir = 1; m_cnt = 0; m_phase = -1; m_pulse = 0;
            return;
        end
        m_pulse = 0;
        if (next_req ^ prev_req) begin
            m_pend = 1;
            m_dir  = next_req ? 1 : -1;
        end
        if (!frame_tick) return;
        if (FADE && m_phase >= 0) begin
            m_phase++;
            if (m_phase == 7) m_switch();
            if (m_phase == 14) m_phase = -1;
        end else if (m_pend) begin
            if (FADE) m_phase = 0;
            else m_switch();
        end else if (auto_en && !paused) begin
            if (m_cnt == FP - 1) begin
                m_cnt = 0;
                m_pend = 1;
                m_dir = 1;
                if (FADE) m_phase = 0;
                else m_switch();
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: inputs already driven are sampled, model advances, outputs
    // are compared 1 time unit after the edge, then pulse inputs drop.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("sel", int'(pattern_sel), m_sel);
        chk("fade", int'(fade_level), m_fade());
        chk("pulse", int'(switch_pulse), m_pulse);
        chk("busy", int'(busy), (FADE && m_phase >= 0) ? 1 : 0);
        frame_tick = 1'b0;
        next_req   = 1'b0;
        prev_req   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic tick(input int gap);
        frame_tick = 1'b1;
        cyc();
        idle(gap - 1);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) tick(gap);
    endtask

    typedef struct {
        bit nxt;
        bit prv;
        bit on_tick;
        int exp_sel;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 2};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 2};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1};

        // Reset and idle ticks with auto advance off.
        rst = 1'b1;
        idle(2);
        chk("rst_sel", int'(pattern_sel), 0);
        chk("rst_fade", int'(fade_level), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        ticks(20, 4);
        chk("t1_sel", int'(pattern_sel), 0);

        // Auto advance after the 4th tick, ticks 10 cycles apart.
        auto_en = 1'b1;
        ticks(3, 10);
        chk("t2_pre", int'(pattern_sel), 0);
        frame_tick = 1'b1;
        cyc();
        if (FADE) begin
            chk("t2_fade1", int'(fade_level), 1);
            chk("t2_busy", int'(busy), 1);
        end else begin
            chk("t2_sel", int'(pattern_sel), 1);
            chk("t2_pulse", int'(switch_pulse), 1);
        end
        auto_en = 1'b0;
        idle(9);
        ticks(15, 10);
        chk("t2_end_sel", int'(pattern_sel), 1);
        chk("t2_end_busy", int'(busy), 0);

        // Table of manual requests, each followed by enough ticks to settle.
        for (int v = 0; v < 8; v++) begin
            next_req   = vecs[v].nxt;
            prev_req   = vecs[v].prv;
            frame_tick = vecs[v].on_tick;
            cyc();
            idle(2);
            ticks(16, 3);
            chk($sformatf("vec%0d_sel", v), int'(pattern_sel), vecs[v].exp_sel);
            chk($sformatf("vec%0d_fade", v), int'(fade_level), 0);
            chk($sformatf("vec%0d_busy", v), int'(busy), 0);
        end

        // next then prev before the tick: the later -1 is used (1 -> 0).
        next_req = 1'b1;
        cyc();
        idle(2);
        prev_req = 1'b1;
        cyc();
        ticks(16, 3);
        chk("last_wins", int'(pattern_sel), 0);

        // Paused freezes the counter; release needs the full 4 ticks.
        auto_en = 1'b1;
        paused  = 1'b1;
        ticks(10, 3);
        chk("pause_sel", int'(pattern_sel), 0);
        paused = 1'b0;
        ticks(3, 3);
        chk("pause_hold", int'(pattern_sel), 0);
        tick(3);
        auto_en = 1'b0;
        ticks(16, 3);
        chk("pause_adv", int'(pattern_sel), 1);

        // paused raised during the fade-out does not stall it.
        next_req = 1'b1;
        cyc();
        ticks(4, 3);
        paused = 1'b1;
        ticks(13, 3);
        chk("pause_fade_sel", int'(pattern_sel), 2);
        chk("pause_fade_busy", int'(busy), 0);
        paused = 1'b0;

        // Reset in the middle of the fade-in phase.
        next_req = 1'b1;
        cyc();
        ticks(10, 3);
        if (FADE) chk("mid_busy", int'(busy), 1);
        rst = 1'b1;
        cyc();
        chk("mid_rst_sel", int'(pattern_sel), 0);
        chk("mid_rst_fade", int'(fade_level), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        idle(2);

        // Request is served on the next tick, not before.
        next_req = 1'b1;
        cyc();
        idle(3);
        chk("serve_wait", int'(pattern_sel), 0);
        frame_tick = 1'b1;
        cyc();
        if (FADE) begin
            chk("serve_fade", int'(fade_level), 1);
        end else begin
            chk("serve_sel", int'(pattern_sel), 1);
            chk("serve_pulse", int'(switch_pulse), 1);
            chk("serve_fade0", int'(fade_level), 0);
        end
        ticks(16, 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            next_req   = ($urandom_range(0, 15) == 0);
            prev_req   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
            if ($urandom_range(0, 31) == 0) paused = ~paused;
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
